// File: rtl/uart_loopback_tester.sv
// uart_loopback_tester
//   Host-side partner of a UART loopback build. Sends NBYTES 8N1 frames out
//   txpin, deserialises the echo on rxpin and compares each echoed byte with
//   the byte sent. Reports pass/fail and a saturating error count.
//   Optional feature macro: UART_TESTER_PRBS_EN
//     defined   -> sent bytes come from an 8-bit Fibonacci LFSR (seed 0x01)
//     undefined -> sent byte is the low 8 bits of the frame index
module uart_loopback_tester #(
  parameter int SYSCLKFRQ    = 12000000,
  parameter int BITCLKFRQ    = 115200,
  parameter int NBYTES       = 256,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rxpin,
  output logic       txpin,
  output logic       busy,
  output logic       pass,
  output logic       fail,
  output logic [7:0] errcnt,
  output logic [7:0] lastrx
);

  // Rounded divider for a tick at 8x the bit rate.
  localparam int DIV      = (SYSCLKFRQ + 4 * BITCLKFRQ) / (8 * BITCLKFRQ);
  localparam int DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TO_TICKS = TIMEOUT_BITS * 8;
  localparam int TO_W     = $clog2(TO_TICKS + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_TICKS - 1);
  localparam logic [15:0]      LAST_IDX = 16'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Error counter increment that sticks at all-ones.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : (v + 8'd1);
  endfunction

  state_t           state_r;
  state_t           state_n;
  logic [DIV_W-1:0] div_cnt_r;
  logic             tick_s;
  logic [15:0]      idx_r;
  logic [6:0]       tx_cnt_r;
  logic [TO_W-1:0]  wait_cnt_r;
  logic [7:0]       tx_data_s;
  logic [9:0]       tx_frame_s;
  logic             armed_s;

  logic             rx_prev_r;
  logic             rx_busy_r;
  logic [2:0]       rx_tcnt_r;
  logic [3:0]       rx_bcnt_r;
  logic [7:0]       rx_shift_r;
  logic             rx_sample_s;
  logic             rx_cmpl_s;

  logic             got_r;
  logic [7:0]       got_byte_r;
  logic             got_ferr_r;
  logic             got_s;
  logic [7:0]       got_byte_s;
  logic             got_ferr_s;

  logic             accept_s;
  logic             check_s;
  logic             err_s;
  logic             last_s;
  logic [7:0]       errcnt_nx_s;

  logic             txpin_r;
  logic             busy_r;
  logic             pass_r;
  logic             fail_r;
  logic [7:0]       errcnt_r;
  logic [7:0]       lastrx_r;

  assign tick_s     = (div_cnt_r == DIV_LAST);
  assign tx_frame_s = {1'b1, tx_data_s, 1'b0};
  assign armed_s    = (state_r == S_SEND) || (state_r == S_WAIT);

`ifdef UART_TESTER_PRBS_EN
  logic [7:0] lfsr_r;

  // Fibonacci LFSR step: shift left, feedback b7^b5^b4^b3 into b0.
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Pattern source: reseeded per run, advanced once per checked frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_r <= 8'h01;
    end else if (accept_s) begin
      lfsr_r <= 8'h01;
    end else if (check_s) begin
      lfsr_r <= lfsr_step(lfsr_r);
    end
  end

  assign tx_data_s = lfsr_r;
`else
  assign tx_data_s = idx_r[7:0];
`endif

  // Free-running divider producing the 8x oversampling tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_r <= '0;
    end else if (div_cnt_r == DIV_LAST) begin
      div_cnt_r <= '0;
    end else begin
      div_cnt_r <= div_cnt_r + DIV_W'(1);
    end
  end

  // Start bit is sampled 4 ticks after the edge, later bits every 8 ticks.
  assign rx_sample_s = rx_busy_r && tick_s &&
                       ((rx_bcnt_r == 4'd0) ? (rx_tcnt_r == 3'd3) : (rx_tcnt_r == 3'd7));
  assign rx_cmpl_s   = rx_sample_s && (rx_bcnt_r == 4'd9);

  // Receiver: edge detect, mid-bit sampling, glitch rejection on the start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_prev_r  <= 1'b1;
      rx_busy_r  <= 1'b0;
      rx_tcnt_r  <= 3'd0;
      rx_bcnt_r  <= 4'd0;
      rx_shift_r <= 8'h00;
    end else begin
      rx_prev_r <= rxpin;
      if (!rx_busy_r) begin
        if (rx_prev_r && !rxpin) begin
          rx_busy_r <= 1'b1;
          rx_tcnt_r <= 3'd0;
          rx_bcnt_r <= 4'd0;
        end
      end else if (rx_sample_s) begin
        rx_tcnt_r <= 3'd0;
        if (rx_bcnt_r == 4'd0) begin
          if (rxpin) begin
            rx_busy_r <= 1'b0;
          end else begin
            rx_bcnt_r <= 4'd1;
          end
        end else if (rx_bcnt_r == 4'd9) begin
          rx_busy_r <= 1'b0;
        end else begin
          rx_shift_r <= {rxpin, rx_shift_r[7:1]};
          rx_bcnt_r  <= rx_bcnt_r + 4'd1;
        end
      end else if (tick_s) begin
        rx_tcnt_r <= rx_tcnt_r + 3'd1;
      end
    end
  end

  // The loopback echo usually completes while still sending, so hold it for WAIT.
  assign got_s      = got_r || (rx_cmpl_s && armed_s);
  assign got_byte_s = got_r ? got_byte_r : rx_shift_r;
  assign got_ferr_s = got_r ? got_ferr_r : ~rxpin;

  // Capture the first echo of the current frame; later ones are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      got_r      <= 1'b0;
      got_byte_r <= 8'h00;
      got_ferr_r <= 1'b0;
    end else if (accept_s || check_s) begin
      got_r <= 1'b0;
    end else if (rx_cmpl_s && armed_s && !got_r) begin
      got_r      <= 1'b1;
      got_byte_r <= rx_shift_r;
      got_ferr_r <= ~rxpin;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // FSM next state and per-frame check; a completed frame beats a coincident timeout.
  always_comb begin
    state_n  = state_r;
    accept_s = 1'b0;
    check_s  = 1'b0;
    err_s    = 1'b0;
    last_s   = (idx_r == LAST_IDX);
    case (state_r)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_n  = S_SEND;
          accept_s = 1'b1;
        end else begin
          state_n = state_r;
        end
      end
      S_SEND: begin
        if (tick_s && (tx_cnt_r == 7'd79)) begin
          state_n = S_WAIT;
        end else begin
          state_n = state_r;
        end
      end
      S_WAIT: begin
        if (got_s) begin
          check_s = 1'b1;
          err_s   = (got_byte_s != tx_data_s) || got_ferr_s;
        end else if (tick_s && (wait_cnt_r == TO_LAST)) begin
          check_s = 1'b1;
          err_s   = 1'b1;
        end else begin
          check_s = 1'b0;
          err_s   = 1'b0;
        end
        if (check_s) begin
          state_n = last_s ? S_DONE : S_SEND;
        end else begin
          state_n = state_r;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  assign errcnt_nx_s = err_s ? sat_inc(errcnt_r) : errcnt_r;

  // Frame index, error count and final verdict.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r    <= 16'd0;
      errcnt_r <= 8'h00;
      pass_r   <= 1'b0;
      fail_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      busy_r <= (state_n == S_SEND) || (state_n == S_WAIT);
      if (accept_s) begin
        idx_r    <= 16'd0;
        errcnt_r <= 8'h00;
        pass_r   <= 1'b0;
        fail_r   <= 1'b0;
      end else if (check_s) begin
        errcnt_r <= errcnt_nx_s;
        if (last_s) begin
          pass_r <= (errcnt_nx_s == 8'h00);
          fail_r <= (errcnt_nx_s != 8'h00);
        end else begin
          idx_r <= idx_r + 16'd1;
        end
      end
    end
  end

  // Transmit serializer: txpin changes on ticks, one frame bit per 8 ticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_cnt_r <= 7'd0;
      txpin_r  <= 1'b1;
    end else if (state_r == S_SEND) begin
      if (tick_s) begin
        txpin_r  <= tx_frame_s[tx_cnt_r[6:3]];
        tx_cnt_r <= tx_cnt_r + 7'd1;
      end
    end else begin
      tx_cnt_r <= 7'd0;
      txpin_r  <= 1'b1;
    end
  end

  // Echo timeout counter, restarted on every WAIT entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_r <= '0;
    end else if (state_r != S_WAIT) begin
      wait_cnt_r <= '0;
    end else if (tick_s) begin
      wait_cnt_r <= wait_cnt_r + TO_W'(1);
    end
  end

  // Last echoed byte, including frames with a bad stop bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      lastrx_r <= 8'h00;
    end else if (rx_cmpl_s && armed_s) begin
      lastrx_r <= rx_shift_r;
    end
  end

  assign txpin  = txpin_r;
  assign busy   = busy_r;
  assign pass   = pass_r;
  assign fail   = fail_r;
  assign errcnt = errcnt_r;
  assign lastrx = lastrx_r;

endmodule

// File: tb/tb_uart_loopback_tester.sv
// Self-checking bench for uart_loopback_tester at DIV=8 (64 clocks per bit).
// A txpin monitor checks every frame against an expected-byte queue; an echo
// peer can answer with corrupted frames or glitches.
module tb_uart_loopback_tester;
  localparam int NB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       rxpin;
  logic       txpin;
  logic       busy;
  logic       pass;
  logic       fail;
  logic [7:0] errcnt;
  logic [7:0] lastrx;

  logic       loop_en;
  logic       rx_drive;
  logic       peer_en;
  int         flip_idx;
  int         ferr_idx;
  int         glitch_idx;

  int         cyc = 0;
  int         n_vec = 0;
  int         n_err = 0;

  logic [7:0] exp_q[$];

  logic       mon_busy = 1'b0;
  logic       mon_prev = 1'b1;
  logic       mon_abort;
  int         mon_cnt = 0;
  logic [9:0] mon_bits = 10'h000;
  int         mon_starts = 0;
  int         last_fall = 0;
  logic       last_fall_ok = 1'b0;
  int         exp_gap;
  int         run_idx = 0;
  int         echo_idx = 0;
  logic [7:0] mon_byte = 8'h00;
  event       frame_ev;

  assign rxpin = loop_en ? txpin : rx_drive;

  uart_loopback_tester #(
    .SYSCLKFRQ   (64),
    .BITCLKFRQ   (1),
    .NBYTES      (NB),
    .TIMEOUT_BITS(20)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .rxpin (rxpin),
    .txpin (txpin),
    .busy  (busy),
    .pass  (pass),
    .fail  (fail),
    .errcnt(errcnt),
    .lastrx(lastrx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] exp_byte(input int i);
`ifdef UART_TESTER_PRBS_EN
    case (i)
      0: return 8'h01;
      1: return 8'h02;
      2: return 8'h04;
      default: return 8'h08;
    endcase
`else
    return 8'(i);
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // txpin monitor: decode each frame at mid-bit and score it
  always @(negedge clk) begin
    if (mon_abort) begin
      mon_busy = 1'b0;
      mon_prev = 1'b1;
    end else if (!mon_busy) begin
      if (mon_prev && !txpin) begin
        mon_busy = 1'b1;
        mon_cnt  = 0;
        mon_starts++;
        if (last_fall_ok && exp_gap != 0) chk("frame_gap", cyc - last_fall, exp_gap);
        last_fall    = cyc;
        last_fall_ok = 1'b1;
      end
      mon_prev = txpin;
    end else begin
      mon_cnt++;
      if (mon_cnt % 64 == 32) mon_bits[mon_cnt / 64] = txpin;
      if (mon_cnt == 608) begin
        mon_busy = 1'b0;
        mon_prev = txpin;
        chk("tx_start_bit", 32'(mon_bits[0]), 32'd0);
        chk("tx_stop_bit", 32'(mon_bits[9]), 32'd1);
        mon_byte = mon_bits[8:1];
        chk("tx_frame_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) chk("tx_byte", 32'(mon_byte), 32'(exp_q.pop_front()));
        echo_idx = run_idx;
        run_idx++;
        ->frame_ev;
      end
    end
  end

  task automatic echo(input int idx, input logic [7:0] b);
    logic [7:0] e;
    e = b ^ ((idx == flip_idx) ? 8'h01 : 8'h00);
    repeat (64) @(negedge clk);
    if (idx == glitch_idx) begin
      rx_drive = 1'b0;
      repeat (8) @(negedge clk);
      rx_drive = 1'b1;
      repeat (64) @(negedge clk);
    end
    rx_drive = 1'b0;
    repeat (64) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drive = e[i];
      repeat (64) @(negedge clk);
    end
    rx_drive = (idx == ferr_idx) ? 1'b0 : 1'b1;
    repeat (64) @(negedge clk);
    rx_drive = 1'b1;
  endtask

  // echo peer: answers each decoded frame after the DUT has entered WAIT
  initial begin
    rx_drive = 1'b1;
    forever begin
      @(frame_ev);
      if (peer_en) echo(echo_idx, mon_byte);
    end
  end

  task automatic push_run();
    for (int i = 0; i < NB; i++) exp_q.push_back(exp_byte(i));
  endtask

  task automatic pulse_start();
    @(negedge clk);
    last_fall_ok = 1'b0;
    run_idx      = 0;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_in_time"}, 32'(n < 20000), 32'd1);
    repeat (4) @(negedge clk);
    chk({tag, "_all_frames_seen"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_done(input string tag, input logic p, input logic [7:0] ec,
                            input logic [7:0] lr);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_pass"}, 32'(pass), 32'(p));
    chk({tag, "_fail"}, 32'(fail), 32'(!p));
    chk({tag, "_errcnt"}, 32'(errcnt), 32'(ec));
    chk({tag, "_lastrx"}, 32'(lastrx), 32'(lr));
  endtask

  initial begin
    int base;
    int n;
    logic [7:0] b1;
    rst        = 1'b1;
    start      = 1'b0;
    loop_en    = 1'b0;
    peer_en    = 1'b0;
    flip_idx   = -1;
    ferr_idx   = -1;
    glitch_idx = -1;
    exp_gap    = 0;
    mon_abort  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_txpin", 32'(txpin), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_fail", 32'(fail), 32'd0);
    chk("rst_errcnt", 32'(errcnt), 32'd0);
    chk("rst_lastrx", 32'(lastrx), 32'd0);

    // 1: plain loopback, frames back to back
    loop_en = 1'b1;
    exp_gap = 640;
    push_run();
    pulse_start();
    chk("t1_busy_after_start", 32'(busy), 32'd1);
    wait_done("t1");
    check_done("t1", 1'b1, 8'h00, exp_byte(3));
    repeat (100) @(negedge clk);
    chk("t1_pass_held", 32'(pass), 32'd1);

    // 2: no echo, every byte times out 160 ticks after its stop bit
    loop_en = 1'b0;
    exp_gap = 1920;
    push_run();
    pulse_start();
    wait_done("t2");
    check_done("t2", 1'b0, 8'h04, exp_byte(3));

    // 3: echo with bit0 of byte 2 flipped
    exp_gap  = 0;
    peer_en  = 1'b1;
    flip_idx = 2;
    push_run();
    pulse_start();
    wait_done("t3");
    check_done("t3", 1'b0, 8'h01, exp_byte(3));

    // 4: stop bit 0 on byte 1, harmless 1-tick glitch before echo of byte 2
    flip_idx   = -1;
    ferr_idx   = 1;
    glitch_idx = 2;
    push_run();
    pulse_start();
    wait_done("t4");
    check_done("t4", 1'b0, 8'h01, exp_byte(3));

    // 5: reset in the middle of data bit 4 of byte 1
    ferr_idx   = -1;
    glitch_idx = -1;
    flip_idx   = 0;
    push_run();
    base = mon_starts;
    pulse_start();
    n = 0;
    while (mon_starts < base + 2 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("t5_second_frame_seen", 32'(n < 5000), 32'd1);
    repeat (350) @(negedge clk);
    b1 = exp_byte(1);
    chk("t5_txpin_data4", 32'(txpin), 32'(b1[4]));
    chk("t5_errcnt_before_rst", 32'(errcnt), 32'd1);
    mon_abort = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_rst_txpin", 32'(txpin), 32'd1);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_errcnt", 32'(errcnt), 32'd0);
    chk("t5_rst_fail", 32'(fail), 32'd0);
    exp_q.delete();
    peer_en  = 1'b0;
    flip_idx = -1;
    repeat (100) @(negedge clk);
    mon_abort = 1'b0;
    chk("t5_idle_txpin", 32'(txpin), 32'd1);
    loop_en = 1'b1;
    exp_gap = 640;
    push_run();
    pulse_start();
    wait_done("t5r");
    check_done("t5r", 1'b1, 8'h00, exp_byte(3));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
